// File: rtl/uart_pkg.sv
// Shared UART TX definitions: arbiter state encoding, default byte width and
// parity type encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1 (mod NUM_REQ)
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    gnt_id_c
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Visit last+1 .. last+NUM_REQ; the final step revisits last itself.
  always_comb begin
    gnt_c    = '0;
    gnt_id_c = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_c[idx]  = 1'b1;
        gnt_id_c    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX serializer between NUM_REQ
// requesters; tracks each frame via Busy and recovers if Busy never rises.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BUSY_TMO   = 4,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]            Req_Par_Typ,
  input  logic [NUM_REQ-1:0]            Req_Par_En,
  output logic [NUM_REQ-1:0]            Ack,
  output logic [DATA_WIDTH-1:0]         P_Data,
  output logic                          PAR_TYP,
  output logic                          PAR_EN,
  output logic                          Data_Valid,
  input  logic                          Busy,
  output logic [ID_W-1:0]               Active_Id,
  output logic                          Frame_Done,
  output logic                          Tmo_Err
);

  localparam int unsigned     CNT_W    = $clog2(BUSY_TMO) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

  arb_state_t                state, state_next;
  logic [ID_W-1:0]           last;
  logic [CNT_W-1:0]          tmo_cnt;
  logic [NUM_REQ-1:0]        gnt_c;
  logic [ID_W-1:0]           gnt_id_c;
  logic                      grant_c;
  logic [DATA_WIDTH-1:0]     sel_data_c;
  logic                      sel_typ_c;
  logic                      sel_en_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req      (Req),
    .last     (last),
    .gnt_c    (gnt_c),
    .gnt_id_c (gnt_id_c)
  );

  // Pick the granted requester's byte and parity configuration.
  always_comb begin
    sel_data_c = '0;
    sel_typ_c  = PAR_EVEN;
    sel_en_c   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_data_c = Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_typ_c  = Req_Par_Typ[i];
        sel_en_c   = Req_Par_En[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Frame_Done and Tmo_Err are decoded from state and Busy so they land in
  // the same cycle that ends the frame.
  always_comb begin
    state_next = state;
    grant_c    = 1'b0;
    Frame_Done = 1'b0;
    Tmo_Err    = 1'b0;
    case (state)
      IDLE: begin
        if (|Req && !Busy) begin
          grant_c    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (Busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          Tmo_Err    = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!Busy) begin
          Frame_Done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture registers only load on a grant, so they hold for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_Data     <= '0;
      PAR_TYP    <= PAR_EVEN;
      PAR_EN     <= 1'b0;
      Active_Id  <= '0;
      last       <= ID_W'(NUM_REQ - 1);
      Data_Valid <= 1'b0;
      Ack        <= '0;
      tmo_cnt    <= '0;
    end else begin
      Data_Valid <= 1'b0;
      Ack        <= '0;
      if (grant_c) begin
        P_Data     <= sel_data_c;
        PAR_TYP    <= sel_typ_c;
        PAR_EN     <= sel_en_c;
        Active_Id  <= gnt_id_c;
        last       <= gnt_id_c;
        Data_Valid <= 1'b1;
        Ack        <= gnt_c;
      end
      if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                    tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART_TX Busy model.
module tb_uart_tx_arbiter;

  localparam int FRAME_LEN = 11;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  par_typ;
  logic [3:0]  par_en;
  logic [3:0]  ack;
  logic [7:0]  p_data;
  logic        par_typ_o;
  logic        par_en_o;
  logic        data_valid;
  logic        busy;
  logic        busy_m;
  logic        busy_force;
  logic [1:0]  active_id;
  logic        frame_done;
  logic        tmo_err;

  bit          model_en = 1'b1;
  logic [7:0]  model_byte;
  int          checks = 0;
  int          errors = 0;
  int          dv_cnt = 0;
  int          fd_cnt = 0;
  int          tmo_cnt = 0;
  int          ack_cnt = 0;
  int          viol_cnt = 0;

  assign busy = busy_m | busy_force;

  uart_tx_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .BUSY_TMO   (4)
  ) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .Req         (req),
    .Req_Data    (req_data),
    .Req_Par_Typ (par_typ),
    .Req_Par_En  (par_en),
    .Ack         (ack),
    .P_Data      (p_data),
    .PAR_TYP     (par_typ_o),
    .PAR_EN      (par_en_o),
    .Data_Valid  (data_valid),
    .Busy        (busy),
    .Active_Id   (active_id),
    .Frame_Done  (frame_done),
    .Tmo_Err     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART_TX stand-in: Busy rises one cycle after Data_Valid for FRAME_LEN cycles.
  initial begin
    logic       dv_s;
    logic [7:0] pd_s;
    int         left;
    busy_m     = 1'b0;
    model_byte = '0;
    left       = 0;
    forever begin
      @(negedge clk);
      dv_s = data_valid;
      pd_s = p_data;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_m = 1'b0;
        left   = 0;
      end else if (left > 0) begin
        left--;
        busy_m = (left != 0);
      end else if (dv_s && model_en) begin
        busy_m     = 1'b1;
        left       = FRAME_LEN;
        model_byte = pd_s;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (data_valid) dv_cnt++;
      if (frame_done) fd_cnt++;
      if (tmo_err) tmo_cnt++;
      ack_cnt += $countones(ack);
      if (data_valid && busy) viol_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sel 0: Data_Valid, sel 1: Frame_Done; returns negedges waited (0 = timeout).
  task automatic wait_for(input string tag, input int sel, input int budget, output int waited);
    logic hit;
    waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? data_valid : frame_done;
      if (hit && waited == 0) begin
        waited = i;
        break;
      end
    end
    checks++;
    assert (waited != 0) else begin
      errors++;
      $error("FAIL %s: observed timeout after %0d cycles expected event", tag, budget);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic en, input logic t);
    return {1'b1, en ? (^d ^ t) : 1'b1, d, 1'b0};
  endfunction

  initial begin
    int        w;
    logic [1:0] exp_id [5];
    logic [7:0] exp_byte [5];
    exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_byte = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst_n = 1'b0; req = '0; req_data = '0; par_typ = '0; par_en = '0; busy_force = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ack, p_data, par_typ_o, par_en_o, data_valid, active_id, frame_done, tmo_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, even parity enabled
    req_data = 32'h0000_00A5; par_en = 4'b0001; par_typ = 4'b0000; req = 4'b0001;
    @(negedge clk);
    check("single_dv", data_valid, 1);
    check("single_ack", ack, 4'b0001);
    check("single_pdata", p_data, 8'hA5);
    check("single_par_en", par_en_o, 1);
    check("single_par_typ", par_typ_o, 0);
    check("single_frame", frame_bits(p_data, par_en_o, par_typ_o), 11'h54A);
    req = '0;
    wait_for("single_fd", 1, 40, w);
    @(negedge clk);
    check("single_fd_count", fd_cnt, 1);

    // Contention from reset: order 0,1,2,3,0, frames every FRAME_LEN+3 cycles
    rst_n = 1'b0;
    @(negedge clk);
    req_data = 32'h4433_2211; par_en = '0; par_typ = '0; req = 4'b1111; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_for("rr_dv", 0, 40, w);
      if (k > 0) check("rr_spacing", w, 14);
      check("rr_id", active_id, exp_id[k]);
      check("rr_ack", ack, 4'b0001 << exp_id[k]);
      check("rr_pdata", p_data, exp_byte[k]);
    end
    req = '0;
    wait_for("rr_fd", 1, 40, w);
    @(negedge clk);
    check("rr_fd_count", fd_cnt, 6);

    // Fairness after wrap
    req_data = 32'h00B2_00B0; req = 4'b0100;
    wait_for("fair_dv0", 0, 40, w);
    check("fair_first_id", active_id, 2);
    req = '0;
    wait_for("fair_fd0", 1, 40, w);
    @(negedge clk);
    req = 4'b0101;
    wait_for("fair_dv1", 0, 40, w);
    check("fair_wrap_id", active_id, 0);
    check("fair_wrap_pdata", p_data, 8'hB0);
    req = 4'b0100;
    wait_for("fair_dv2", 0, 40, w);
    check("fair_next_id", active_id, 2);
    check("fair_next_ack", ack, 4'b0100);
    req = '0;
    wait_for("fair_fd2", 1, 40, w);
    @(negedge clk);

    // Busy timeout: model silenced
    model_en = 1'b0; req_data = 32'h0000_5A00; req = 4'b0010;
    wait_for("tmo_dv", 0, 40, w);
    check("tmo_id", active_id, 1);
    req = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("tmo_pulse_c%0d", i), tmo_err, (i == 4) ? 1 : 0);
    end
    check("tmo_no_fd", fd_cnt, 9);
    @(negedge clk);
    check("tmo_after", tmo_err, 0);

    // Req withdrawn in ISSUE; one-cycle latency also shows the FSM is idle
    model_en = 1'b1; req_data = 32'h0000_3C00; par_en = 4'b0010; par_typ = 4'b0010; req = 4'b0010;
    @(negedge clk);
    check("wd_dv", data_valid, 1);
    check("wd_ack", ack, 4'b0010);
    check("wd_pdata", p_data, 8'h3C);
    check("wd_par", 32'({par_en_o, par_typ_o}), 32'b11);
    req = '0; req_data = 32'hFFFF_FFFF;
    wait_for("wd_fd", 1, 40, w);
    check("wd_hold_pdata", p_data, 8'h3C);
    check("wd_hold_id", active_id, 1);
    check("wd_model_byte", model_byte, 8'h3C);
    @(negedge clk);

    // Busy high while idle blocks the grant
    req_data = 32'h0000_00C3; par_en = '0; par_typ = '0; busy_force = 1'b1; req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_block_dv", data_valid, 0);
    end
    busy_force = 1'b0;
    @(negedge clk);
    check("busy_release_dv", data_valid, 1);
    check("busy_release_id", active_id, 0);
    check("busy_release_pdata", p_data, 8'hC3);
    req = '0;
    wait_for("busy_fd", 1, 40, w);
    @(negedge clk);

    // Reset mid-frame
    req_data = 32'h7700_0000; req = 4'b1000;
    wait_for("rst_dv0", 0, 40, w);
    check("rst_pre_id", active_id, 3);
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({ack, p_data, par_typ_o, par_en_o, data_valid, active_id, frame_done, tmo_err}), 32'd0);
    @(negedge clk);
    req_data = 32'h9900_0000; req = 4'b1000; rst_n = 1'b1;
    @(negedge clk);
    check("rst_post_dv", data_valid, 1);
    check("rst_post_ack", ack, 4'b1000);
    check("rst_post_id", active_id, 3);
    check("rst_post_pdata", p_data, 8'h99);
    req = '0;
    wait_for("rst_fd", 1, 40, w);
    @(negedge clk);

    check("total_dv", dv_cnt, 14);
    check("total_fd", fd_cnt, 12);
    check("total_tmo", tmo_cnt, 1);
    check("total_ack", ack_cnt, 14);
    check("dv_while_busy", viol_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
